// File: rtl/code_tracker_pkg.sv
// Shared widths, settle depth and FSM state type for the code tracker.
package code_tracker_pkg;
  localparam int CODE_W      = 10;
  localparam int THERM_W     = 16;
  localparam int SETTLE_SKIP = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    TRACK  = 2'd2
  } state_t;
endpackage

// File: rtl/code_tracker_therm_decode.sv
// Coarse thermometer: bit k is set when k is below the 4-bit coarse code.
module therm_decode
  import code_tracker_pkg::*;
(
  input  logic [3:0]         coarse,
  output logic [THERM_W-1:0] therm
);
  generate
    for (genvar gi = 0; gi < THERM_W; gi++) begin : g_bit
      assign therm[gi] = (4'(gi) < coarse);
    end
  endgenerate
endmodule

// File: rtl/code_tracker.sv
// Delay-code tracker: SAR load, filtered +/-1 stepping, lock detection.
// Optional freeze input enabled by defining CODE_TRACK_FREEZE_EN.
module code_tracker
  import code_tracker_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic              clk4,
  input  logic              rst,
  input  logic              load,
  input  logic [CODE_W-1:0] sar_code,
  input  logic              COMP,
  input  logic              comp_valid,
`ifdef CODE_TRACK_FREEZE_EN
  input  logic              freeze,
`endif
  output logic [CODE_W-1:0] Q,
  output logic [THERM_W-1:0] T,
  output logic [THERM_W-1:0] Tb,
  output logic              locked
);
  localparam logic signed [4:0] FILT_POS  = 5'(FILT_LEN);
  localparam logic signed [4:0] FILT_NEG  = -5'(FILT_LEN);
  localparam logic [7:0]        LOCK_MAX  = 8'(LOCK_CNT);
  localparam logic [1:0]        SKIP_LAST = 2'(SETTLE_SKIP - 1);

  state_t              state_reg;
  logic signed [4:0]   acc_reg;
  logic signed [4:0]   acc_next;
  logic [7:0]          lock_cnt_reg;
  logic [7:0]          lock_cnt_next;
  logic [1:0]          settle_cnt_reg;
  logic [CODE_W-1:0]   q_reg;
  logic [CODE_W-1:0]   q_next;
  logic [THERM_W-1:0]  t_reg;
  logic [THERM_W-1:0]  therm_next;
  logic                locked_reg;
  logic                frz;
  logic                sample;
  logic                hit_pos;
  logic                hit_neg;
  logic                step;

`ifdef CODE_TRACK_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  assign sample        = (state_reg == TRACK) && comp_valid && !frz;
  assign acc_next      = COMP ? (acc_reg - 5'sd1) : (acc_reg + 5'sd1);
  assign hit_pos       = sample && (acc_next == FILT_POS);
  assign hit_neg       = sample && (acc_next == FILT_NEG);
  // A threshold hit against a rail is not a step.
  assign step          = !load && ((hit_pos && !(&q_reg)) || (hit_neg && (q_reg != '0)));
  assign lock_cnt_next = lock_cnt_reg + 8'd1;

  always_comb begin
    q_next = q_reg;
    if (load)
      q_next = sar_code;
    else if (hit_pos && !(&q_reg))
      q_next = q_reg + 10'd1;
    else if (hit_neg && (q_reg != '0))
      q_next = q_reg - 10'd1;
  end

  // T is registered from the next code so it moves together with Q.
  therm_decode u_therm (
    .coarse (q_next[CODE_W-1 -: 4]),
    .therm  (therm_next)
  );

  always_ff @(posedge clk4) begin
    if (rst) begin
      state_reg      <= IDLE;
      q_reg          <= '0;
      t_reg          <= '0;
      acc_reg        <= '0;
      lock_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      locked_reg     <= 1'b0;
    end else begin
      q_reg <= q_next;
      t_reg <= therm_next;
      if (load) begin
        state_reg      <= SETTLE;
        acc_reg        <= '0;
        lock_cnt_reg   <= '0;
        settle_cnt_reg <= '0;
        locked_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: ;
          SETTLE: begin
            if (comp_valid) begin
              if (settle_cnt_reg == SKIP_LAST) begin
                state_reg      <= TRACK;
                settle_cnt_reg <= '0;
              end else begin
                settle_cnt_reg <= settle_cnt_reg + 2'd1;
              end
            end
          end
          TRACK: begin
            if (sample) begin
              if (step) begin
                state_reg      <= SETTLE;
                acc_reg        <= '0;
                lock_cnt_reg   <= '0;
                settle_cnt_reg <= '0;
                locked_reg     <= 1'b0;
              end else begin
                acc_reg <= (hit_pos || hit_neg) ? 5'sd0 : acc_next;
                if (lock_cnt_reg != LOCK_MAX) begin
                  lock_cnt_reg <= lock_cnt_next;
                  locked_reg   <= (lock_cnt_next >= LOCK_MAX);
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign Q      = q_reg;
  assign T      = t_reg;
  assign Tb     = ~t_reg;
  assign locked = locked_reg;
endmodule

// File: doc/code_tracker.md
CODE_TRACKER -- requirements
Module: code_tracker

Interface
REQ-001 SHALL take parameter FILT_LEN, default 4: the accumulator magnitude that triggers one code step (range 2..15).
REQ-002 SHALL take parameter LOCK_CNT, default 8: the number of step-free comparison samples before lock (range 1..255).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk4  in  1  tracking clock
- rst  in  1  synchronous active-high reset
- load  in  1  one-cycle pulse; captures sar_code
- sar_code  in  10  converged SAR code
- COMP  in  1  phase result; 1 = CLK_out late (decrease code), 0 = early (increase code)
- comp_valid  in  1  qualifies COMP, one sample per PD window
- Q  out  10  applied delay code
- T  out  16  coarse thermometer of Q[9:6]
- Tb  out  16  complement of T
- locked  out  1  tracking lock flag

Function
REQ-004 SHALL implement the FSM states IDLE, SETTLE and TRACK.
REQ-005 SHALL move from IDLE to SETTLE on load, with Q <= sar_code; comp_valid SHALL be ignored in IDLE.
REQ-006 SHALL, in SETTLE, discard the first 2 comp_valid samples after any code change, then enter TRACK.
REQ-007 SHALL, in TRACK, on each comp_valid: add -1 to a signed accumulator when COMP=1 and +1 when COMP=0.
REQ-008 SHALL, when the accumulator reaches +FILT_LEN, set Q <= Q+1, clear the accumulator and enter SETTLE.
REQ-009 SHALL, when the accumulator reaches -FILT_LEN, set Q <= Q-1, clear the accumulator and enter SETTLE.
REQ-010 SHALL update Q in the cycle after the threshold-crossing comp_valid sample.
REQ-011 SHALL saturate Q at 0 and 1023; a step blocked by saturation SHALL clear the accumulator, stay in TRACK, and not count as a step.
REQ-012 SHALL register T/Tb from the next value of Q, so T/Tb change in the same cycle as Q.
REQ-013 SHALL drive T[k]=1 iff k < Q[9:6], and Tb = ~T.
REQ-014 SHALL count TRACK comp_valid samples since the last step; locked SHALL be 1 once the count reaches LOCK_CNT, with the count saturating.
REQ-015 SHALL clear the lock count and locked on any code step or load.
REQ-016 SHALL give load priority over comp_valid when both occur in the same cycle, in any state: reload Q, clear the accumulator and lock count, enter SETTLE.

Reset
REQ-017 SHALL, on rst=1 at a clk4 edge, set: state IDLE, Q=0, T=16'h0000, Tb=16'hFFFF, locked=0, accumulator=0, lock count=0, settle count=0.
REQ-018 SHALL abort any step in progress when rst is asserted mid-operation, with no partial update of Q.
REQ-019 SHALL give rst priority over load.

Configuration
REQ-020 SHALL, when CODE_TRACK_FREEZE_EN is defined, add input port freeze (1 bit).
REQ-021 SHALL, while freeze=1: suppress steps, hold the accumulator, not advance the lock count; load SHALL still act.
REQ-022 SHALL, when CODE_TRACK_FREEZE_EN is undefined, have no freeze port and track unconditionally.

Structure
REQ-023 SHALL place the following in package code_tracker_pkg: CODE_W=10, THERM_W=16, SETTLE_SKIP=2, and the FSM state enum.
REQ-024 SHALL implement the 4-bit-to-16-bit thermometer as sub-module therm_decode.

Verification
REQ-025 SHALL check: rst for 1 cycle -> Q=0, T=0, Tb=FFFF, locked=0.
REQ-026 SHALL check: load with sar_code=10'd300, then 2 discarded samples, then 4 samples COMP=0 -> Q=301 one cycle after the 4th sample, T=16'h000F.
REQ-027 SHALL check: Q=1023, then 4 samples COMP=0 -> Q stays 1023, state TRACK, locked unchanged.
REQ-028 SHALL check: COMP alternating 1/0 for 8 samples in TRACK -> no step, locked=1 after the 8th sample.
REQ-029 SHALL check: load with sar_code=10'd64 in the same cycle as a threshold-crossing comp_valid -> Q=64, locked=0, state SETTLE.
REQ-030 SHALL check, with CODE_TRACK_FREEZE_EN defined: freeze=1 during 6 samples COMP=1 -> Q unchanged; freeze=0 -> step after further samples.
